simd_dispatch_controller: RTL and testbench

- Sits between warp_scheduler and the NUM_SIMD_CORES SIMD cores.
- Accepts kernel_t descriptors over a valid/ready handshake and buffers them in a small pending queue.
- Launches each buffered kernel on a free core, selected round-robin.
- Tracks per-core busy state and serialises core completions into the single finished_warp_id return channel the scheduler consumes.

---
 rtl/simd_dispatch_controller_pkg.sv | 56 +++++
 rtl/simd_dispatch_controller_rr_arbiter.sv | 34 +++
 rtl/simd_dispatch_controller.sv | 226 ++++++++++++++++++++++
 tb/tb_simd_dispatch_controller.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/simd_dispatch_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : simd_dispatch_controller_pkg
// Description : Shared types and constants for the SIMD dispatch controller:
//               kernel descriptor, core count, thread-count width, the
//               reserved "no warp" id, the per-core state encoding and small
//               index helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package simd_dispatch_controller_pkg;

    localparam int NUM_SIMD_CORES    = 4;
    localparam int LOG2_THREAD_COUNT = 4;
    localparam int CORE_IDX_W        = (NUM_SIMD_CORES > 1) ? $clog2(NUM_SIMD_CORES) : 1;

    // Reserved id shown on finished_warp_id when nothing retires.
    localparam logic [3:0] NO_WARP = 4'hF;

    typedef struct packed {
        logic [3:0]                   warp_id;
        logic [LOG2_THREAD_COUNT-1:0] num_threads;
        logic [31:0]                  pc;
    } kernel_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        RETIRE = 2'd2
    } core_state_t;

    // One-hot grant to binary core index (zero when no bit is set).
    function automatic logic [CORE_IDX_W-1:0] onehot_to_idx(
        input logic [NUM_SIMD_CORES-1:0] oh
    );
        logic [CORE_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_SIMD_CORES; i++) begin
            if (oh[i]) begin
                idx = idx | CORE_IDX_W'(i);
            end
        end
        return idx;
    endfunction

    // Core index + 1, wrapping modulo NUM_SIMD_CORES.
    function automatic logic [CORE_IDX_W-1:0] next_core(
        input logic [CORE_IDX_W-1:0] idx
    );
        if (idx == CORE_IDX_W'(NUM_SIMD_CORES - 1)) begin
            return '0;
        end
        return idx + CORE_IDX_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/simd_dispatch_controller_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : simd_dispatch_controller_rr_arbiter
// Description : Combinational round-robin arbiter. Grants the first asserted
//               request at or after i_ptr, wrapping around to index 0.
// Ports       : i_req   [N]      request vector
//               i_ptr   [PTR_W]  highest-priority index this cycle
//               o_grant [N]      one-hot grant (all zero when no request)
// Revision    : 1.0 - initial release
// ============================================================================
module simd_dispatch_controller_rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant
);

    logic [N-1:0] w_upper_mask;
    logic [N-1:0] w_req_upper;
    logic [N-1:0] w_sel;

    // Bits at index >= i_ptr. If any of those request, the lowest of them
    // wins; otherwise the search wraps and the lowest request overall wins.
    assign w_upper_mask = ~((N'(1) << i_ptr) - N'(1));
    assign w_req_upper  = i_req & w_upper_mask;
    assign w_sel        = (|w_req_upper) ? w_req_upper : i_req;

    // Isolate the lowest set bit (two's-complement trick).
    assign o_grant = w_sel & (~w_sel + N'(1));

endmodule
`default_nettype wire

// File: rtl/simd_dispatch_controller.sv
`default_nettype none
// ============================================================================
// Module      : simd_dispatch_controller
// Description : Buffers kernel descriptors from the warp scheduler in a small
//               circular queue, launches them round-robin onto free SIMD
//               cores, tracks per-core IDLE/RUN/RETIRE state and serialises
//               completions onto a single finished_warp_id channel.
// Ports       : clk, rst            clock / synchronous active-high reset
//               valid_kernel        kernel_in valid
//               kernel_in           kernel descriptor
//               kernel_ready        queue not full
//               core_start   [N]    one-cycle launch pulse per core
//               core_pc      [N]    launch PC per core
//               core_threads [N]    active thread count per core
//               core_warp_id [N]    warp id per core
//               core_done    [N]    completion pulse per core
//               busy_mask    [N]    core not IDLE
//               finished_warp_id    retired warp id for one cycle, else NO_WARP
// Revision    : 1.0 - initial release
// ============================================================================
module simd_dispatch_controller
    import simd_dispatch_controller_pkg::*;
#(
    parameter int KQ_DEPTH = 4      // power of two, >= 2
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              valid_kernel,
    input  kernel_t                                           kernel_in,
    output logic                                              kernel_ready,
    output logic [NUM_SIMD_CORES-1:0]                         core_start,
    output logic [NUM_SIMD_CORES-1:0][31:0]                   core_pc,
    output logic [NUM_SIMD_CORES-1:0][LOG2_THREAD_COUNT-1:0]  core_threads,
    output logic [NUM_SIMD_CORES-1:0][3:0]                    core_warp_id,
    input  logic [NUM_SIMD_CORES-1:0]                         core_done,
    output logic [NUM_SIMD_CORES-1:0]                         busy_mask,
    output logic [3:0]                                        finished_warp_id
);

    localparam int             c_aw      = $clog2(KQ_DEPTH);
    localparam logic [c_aw:0]  c_kq_full = (c_aw + 1)'(KQ_DEPTH);
    localparam logic [c_aw:0]  c_cnt_one = (c_aw + 1)'(1);

    // ------------------------------------------------------------------
    // Pending-kernel queue
    // ------------------------------------------------------------------
    kernel_t          r_kq [KQ_DEPTH];
    logic [c_aw-1:0]  r_head;
    logic [c_aw-1:0]  r_tail;
    logic [c_aw:0]    r_count;

    kernel_t          w_head;
    logic             w_push;
    logic             w_pop;
    logic             w_nonempty;
    logic             w_head_zero;

    // Ready depends on the registered count only, so a full queue never
    // accepts even when a pop happens in the same cycle.
    assign kernel_ready = (r_count != c_kq_full);
    assign w_push       = valid_kernel && kernel_ready;
    assign w_nonempty   = (r_count != '0);
    assign w_head       = r_kq[r_head];
    assign w_head_zero  = (w_head.num_threads == '0);

    // ------------------------------------------------------------------
    // Dispatch / retire arbitration
    // ------------------------------------------------------------------
    logic [NUM_SIMD_CORES-1:0]  w_idle_mask;
    logic [NUM_SIMD_CORES-1:0]  w_retire_mask;
    logic [NUM_SIMD_CORES-1:0]  w_retire_req;
    logic [NUM_SIMD_CORES-1:0]  w_disp_grant;
    logic [NUM_SIMD_CORES-1:0]  w_ret_grant;
    logic [CORE_IDX_W-1:0]      w_disp_idx;
    logic [CORE_IDX_W-1:0]      w_ret_idx;
    logic                       w_dispatch;
    logic                       w_any_ret;

    logic [CORE_IDX_W-1:0]      r_dispatch_ptr;
    logic [CORE_IDX_W-1:0]      r_retire_ptr;
    logic [NUM_SIMD_CORES-1:0]  r_ret_q;        // core reported last cycle
    logic [3:0]                 r_finished;

    // A zero-thread head is dropped without needing a free core; it still
    // uses up this cycle's dispatch slot.
    assign w_dispatch = w_nonempty && !w_head_zero && (|w_idle_mask);
    assign w_pop      = w_nonempty && (w_head_zero || (|w_idle_mask));

    // A core reported last cycle is still in RETIRE this cycle; mask it so
    // it is not reported twice while it drops back to IDLE.
    assign w_retire_req = w_retire_mask & ~r_ret_q;
    assign w_any_ret    = |w_retire_req;

    simd_dispatch_controller_rr_arbiter #(
        .N     (NUM_SIMD_CORES),
        .PTR_W (CORE_IDX_W)
    ) u_dispatch_arb (
        .i_req   (w_idle_mask),
        .i_ptr   (r_dispatch_ptr),
        .o_grant (w_disp_grant)
    );

    simd_dispatch_controller_rr_arbiter #(
        .N     (NUM_SIMD_CORES),
        .PTR_W (CORE_IDX_W)
    ) u_retire_arb (
        .i_req   (w_retire_req),
        .i_ptr   (r_retire_ptr),
        .o_grant (w_ret_grant)
    );

    assign w_disp_idx = onehot_to_idx(w_disp_grant);
    assign w_ret_idx  = onehot_to_idx(w_ret_grant);

    // ------------------------------------------------------------------
    // Queue storage (data only; validity is tracked by r_count)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_kq[r_tail] <= kernel_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + c_aw'(1);
            end
            if (w_pop) begin
                r_head <= r_head + c_aw'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_cnt_one;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_cnt_one;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pointers and retirement report
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dispatch_ptr <= '0;
            r_retire_ptr   <= '0;
            r_ret_q        <= '0;
            r_finished     <= NO_WARP;
        end else begin
            r_ret_q <= w_ret_grant;
            if (w_dispatch) begin
                r_dispatch_ptr <= next_core(w_disp_idx);
            end
            if (w_any_ret) begin
                r_retire_ptr <= next_core(w_ret_idx);
                r_finished   <= core_warp_id[w_ret_idx];
            end else begin
                r_finished   <= NO_WARP;
            end
        end
    end

    assign finished_warp_id = r_finished;

    // ------------------------------------------------------------------
    // Per-core state machines
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_SIMD_CORES; gi++) begin : g_core
        core_state_t                   r_state;
        logic                          r_start;
        logic [31:0]                   r_pc;
        logic [LOG2_THREAD_COUNT-1:0]  r_threads;
        logic [3:0]                    r_warp;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state   <= IDLE;
                r_start   <= 1'b0;
                r_pc      <= '0;
                r_threads <= '0;
                r_warp    <= '0;
            end else begin
                r_start <= 1'b0;
                unique case (r_state)
                    IDLE: begin
                        if (w_dispatch && w_disp_grant[gi]) begin
                            r_state   <= RUN;
                            r_start   <= 1'b1;
                            r_pc      <= w_head.pc;
                            r_threads <= w_head.num_threads;
                            r_warp    <= w_head.warp_id;
                        end
                    end
                    RUN: begin
                        if (core_done[gi]) begin
                            r_state <= RETIRE;
                        end
                    end
                    RETIRE: begin
                        // Leave RETIRE the edge after this core was reported.
                        if (r_ret_q[gi]) begin
                            r_state <= IDLE;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end

        assign w_idle_mask[gi]   = (r_state == IDLE);
        assign w_retire_mask[gi] = (r_state == RETIRE);
        assign busy_mask[gi]     = (r_state != IDLE);
        assign core_start[gi]    = r_start;
        assign core_pc[gi]       = r_pc;
        assign core_threads[gi]  = r_threads;
        assign core_warp_id[gi]  = r_warp;
    end

endmodule
`default_nettype wire

// File: tb/tb_simd_dispatch_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_simd_dispatch_controller
// Description : Self-checking bench for simd_dispatch_controller. A table of
//               per-cycle {inputs, expected outputs} rows drives the main
//               dispatch/retire scenarios; short hand-written sequences cover
//               reset during activity and launch latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simd_dispatch_controller;
    import simd_dispatch_controller_pkg::*;

    logic                                              clk = 1'b0;
    logic                                              rst;
    logic                                              valid_kernel;
    kernel_t                                           kernel_in;
    logic                                              kernel_ready;
    logic [NUM_SIMD_CORES-1:0]                         core_start;
    logic [NUM_SIMD_CORES-1:0][31:0]                   core_pc;
    logic [NUM_SIMD_CORES-1:0][LOG2_THREAD_COUNT-1:0]  core_threads;
    logic [NUM_SIMD_CORES-1:0][3:0]                    core_warp_id;
    logic [NUM_SIMD_CORES-1:0]                         core_done;
    logic [NUM_SIMD_CORES-1:0]                         busy_mask;
    logic [3:0]                                        finished_warp_id;

    always #5 clk = ~clk;

    simd_dispatch_controller #(.KQ_DEPTH(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .valid_kernel     (valid_kernel),
        .kernel_in        (kernel_in),
        .kernel_ready     (kernel_ready),
        .core_start       (core_start),
        .core_pc          (core_pc),
        .core_threads     (core_threads),
        .core_warp_id     (core_warp_id),
        .core_done        (core_done),
        .busy_mask        (busy_mask),
        .finished_warp_id (finished_warp_id)
    );

    typedef struct {
        logic        rst;
        logic        valid;
        kernel_t     k;
        logic [3:0]  done;
        logic        e_ready;
        logic [3:0]  e_start;
        logic [3:0]  e_busy;
        logic [3:0]  e_fin;
        int          chk;       // core whose pc/threads/warp to check, -1 none
        logic [31:0] e_pc;
        logic [3:0]  e_thr;
        logic [3:0]  e_wid;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic kernel_t mk(input logic [3:0] w, input logic [3:0] t, input logic [31:0] pc);
        kernel_t k;
        k.warp_id     = w;
        k.num_threads = t;
        k.pc          = pc;
        return k;
    endfunction

    function automatic void add(
        input logic r, input logic v, input kernel_t k, input logic [3:0] d,
        input logic er, input logic [3:0] es, input logic [3:0] eb, input logic [3:0] ef,
        input int c, input logic [31:0] epc, input logic [3:0] et, input logic [3:0] ew
    );
        vec_t x;
        x.rst = r; x.valid = v; x.k = k; x.done = d;
        x.e_ready = er; x.e_start = es; x.e_busy = eb; x.e_fin = ef;
        x.chk = c; x.e_pc = epc; x.e_thr = et; x.e_wid = ew;
        vecs.push_back(x);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        kernel_t kz;
        int      waited;
        kz = '0;

        rst          = 1'b1;
        valid_kernel = 1'b0;
        kernel_in    = '0;
        core_done    = '0;

        //   rst valid kernel                         done  rdy start busy fin  chk pc            thr wid
        add(1, 0, kz,                              4'h0, 1, 4'h0, 4'h0, 4'hF, 0, 32'h0,        0, 0);  // 0 reset
        add(1, 0, kz,                              4'hF, 1, 4'h0, 4'h0, 4'hF, 0, 32'h0,        0, 0);  // 1 done ignored in reset
        add(0, 1, mk(1, 4, 32'hFFFF_FFFE),         4'h0, 1, 4'h0, 4'h0, 4'hF, -1, 32'h0,       0, 0);  // 2 accept
        add(0, 0, kz,                              4'h0, 1, 4'h1, 4'h1, 4'hF, 0, 32'hFFFF_FFFE, 4, 1); // 3 launch core0
        add(0, 0, kz,                              4'h0, 1, 4'h0, 4'h1, 4'hF, -1, 32'h0,       0, 0);  // 4
        add(0, 0, kz,                              4'h1, 1, 4'h0, 4'h1, 4'hF, -1, 32'h0,       0, 0);  // 5 done core0
        add(0, 0, kz,                              4'h0, 1, 4'h0, 4'h1, 4'h1, -1, 32'h0,       0, 0);  // 6 report warp1
        add(0, 0, kz,                              4'h0, 1, 4'h0, 4'h0, 4'hF, -1, 32'h0,       0, 0);  // 7 idle
        add(1, 0, kz,                              4'h0, 1, 4'h0, 4'h0, 4'hF, 0, 32'h0,        0, 0);  // 8 reset clears pc
        add(0, 1, mk(1, 4, 32'h100),               4'h0, 1, 4'h0, 4'h0, 4'hF, -1, 32'h0,       0, 0);  // 9
        add(0, 1, mk(2, 2, 32'h200),               4'h0, 1, 4'h1, 4'h1, 4'hF, 0, 32'h100,      4, 1);  // 10
        add(0, 1, mk(3, 7, 32'h300),               4'h0, 1, 4'h2, 4'h3, 4'hF, 1, 32'h200,      2, 2);  // 11
        add(0, 1, mk(4, 3, 32'h400),               4'h0, 1, 4'h4, 4'h7, 4'hF, 2, 32'h300,      7, 3);  // 12
        add(0, 1, mk(5, 6, 32'h9090_9090),         4'h0, 1, 4'h8, 4'hF, 4'hF, 3, 32'h400,      3, 4);  // 13
        add(0, 1, mk(6, 1, 32'h600),               4'h0, 1, 4'h0, 4'hF, 4'hF, -1, 32'h0,       0, 0);  // 14
        add(0, 1, mk(7, 0, 32'h700),               4'h0, 1, 4'h0, 4'hF, 4'hF, -1, 32'h0,       0, 0);  // 15
        add(0, 1, mk(8, 2, 32'h800),               4'h0, 0, 4'h0, 4'hF, 4'hF, -1, 32'h0,       0, 0);  // 16 full
        add(0, 1, mk(9, 5, 32'h900),               4'h0, 0, 4'h0, 4'hF, 4'hF, -1, 32'h0,       0, 0);  // 17 held
        add(0, 1, mk(9, 5, 32'h900),               4'h5, 0, 4'h0, 4'hF, 4'hF, -1, 32'h0,       0, 0);  // 18 done 2+0
        add(0, 1, mk(9, 5, 32'h900),               4'h0, 0, 4'h0, 4'hF, 4'h1, -1, 32'h0,       0, 0);  // 19 report 1
        add(0, 1, mk(9, 5, 32'h900),               4'h0, 0, 4'h0, 4'hE, 4'h3, -1, 32'h0,       0, 0);  // 20 report 3
        add(0, 1, mk(9, 5, 32'h900),               4'h0, 1, 4'h1, 4'hB, 4'hF, 0, 32'h9090_9090, 6, 5); // 21 redispatch core0
        add(0, 1, mk(9, 5, 32'h900),               4'h0, 1, 4'h4, 4'hF, 4'hF, 2, 32'h600,      1, 6);  // 22 core2, push k9
        add(0, 0, kz,                              4'h0, 1, 4'h0, 4'hF, 4'hF, -1, 32'h0,       0, 0);  // 23 zero-thread drop
        add(0, 0, kz,                              4'h2, 1, 4'h0, 4'hF, 4'hF, -1, 32'h0,       0, 0);  // 24 done core1
        add(0, 0, kz,                              4'h0, 1, 4'h0, 4'hF, 4'h2, -1, 32'h0,       0, 0);  // 25 report 2
        add(0, 0, kz,                              4'h0, 1, 4'h0, 4'hD, 4'hF, -1, 32'h0,       0, 0);  // 26 core1 idle
        add(0, 0, kz,                              4'h0, 1, 4'h2, 4'hF, 4'hF, 1, 32'h800,      2, 8);  // 27 warp8 not warp7
        add(0, 1, mk(10, 3, 32'hA00),              4'h0, 1, 4'h0, 4'hF, 4'hF, -1, 32'h0,       0, 0);  // 28
        add(0, 1, mk(11, 3, 32'hB00),              4'h0, 1, 4'h0, 4'hF, 4'hF, -1, 32'h0,       0, 0);  // 29 three queued

        foreach (vecs[i]) begin
            rst          = vecs[i].rst;
            valid_kernel = vecs[i].valid;
            kernel_in    = vecs[i].k;
            core_done    = vecs[i].done;
            tick();
            check($sformatf("row%0d kernel_ready", i), 32'(kernel_ready),     32'(vecs[i].e_ready));
            check($sformatf("row%0d core_start", i),   32'(core_start),       32'(vecs[i].e_start));
            check($sformatf("row%0d busy_mask", i),    32'(busy_mask),        32'(vecs[i].e_busy));
            check($sformatf("row%0d finished", i),     32'(finished_warp_id), 32'(vecs[i].e_fin));
            if (vecs[i].chk >= 0) begin
                check($sformatf("row%0d core_pc", i),      core_pc[vecs[i].chk],           vecs[i].e_pc);
                check($sformatf("row%0d core_threads", i), 32'(core_threads[vecs[i].chk]), 32'(vecs[i].e_thr));
                check($sformatf("row%0d core_warp_id", i), 32'(core_warp_id[vecs[i].chk]), 32'(vecs[i].e_wid));
            end
        end

        // Reset with all cores running and three kernels queued; done pulses
        // and a push during reset must leave no trace.
        rst          = 1'b1;
        valid_kernel = 1'b1;
        kernel_in    = mk(13, 2, 32'hD00);
        core_done    = 4'hF;
        tick();
        check("rst busy_mask",    32'(busy_mask),        32'h0);
        check("rst kernel_ready", 32'(kernel_ready),     32'h1);
        check("rst finished",     32'(finished_warp_id), 32'hF);
        check("rst core_start",   32'(core_start),       32'h0);
        check("rst core_pc1",     core_pc[1],            32'h0);
        check("rst warp_id3",     32'(core_warp_id[3]),  32'h0);
        check("rst threads2",     32'(core_threads[2]),  32'h0);
        rst          = 1'b0;
        valid_kernel = 1'b0;
        core_done    = 4'hF;
        tick();
        check("post-rst busy_mask", 32'(busy_mask),        32'h0);
        check("post-rst finished",  32'(finished_warp_id), 32'hF);
        core_done = 4'h0;
        tick();
        check("post-rst finished2", 32'(finished_warp_id), 32'hF);
        check("post-rst no launch", 32'(core_start),       32'h0);
        check("post-rst busy2",     32'(busy_mask),        32'h0);

        // Launch latency: accept edge, then core_start after the next edge.
        valid_kernel = 1'b1;
        kernel_in    = mk(12, 3, 32'hC00);
        tick();
        valid_kernel = 1'b0;
        waited = 0;
        while (waited < 8) begin
            tick();
            waited++;
            if (core_start != '0) break;
        end
        check("latency cycles",     32'(waited),          32'd1);
        check("latency core_start", 32'(core_start),      32'h1);
        check("latency core_pc",    core_pc[0],           32'hC00);
        check("latency threads",    32'(core_threads[0]), 32'h3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
